voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 204 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Polyphonic note-to-voice allocator that scans one voice per cycle
//            and applies retrigger/free/steal priority at a single commit edge.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7
) (
  input  logic                           sys_clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_on,
  input  logic [NOTE_W-1:0]              req_note,
  output logic [NUM_VOICES-1:0]          voice_enable,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
  output logic                           done,
  output logic [$clog2(NUM_VOICES)-1:0]  done_voice,
  output logic                           done_stolen,
  output logic                           done_hit
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] AGE_MAX  = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [IDX_W-1:0]                      scan_idx_q, scan_idx_d;
  logic                                  on_q, on_d;
  logic [NOTE_W-1:0]                     note_q, note_d;
  logic                                  match_found_q, match_found_d;
  logic [IDX_W-1:0]                      match_idx_q, match_idx_d;
  logic                                  free_found_q, free_found_d;
  logic [IDX_W-1:0]                      free_idx_q, free_idx_d;
  logic                                  old_found_q, old_found_d;
  logic [IDX_W-1:0]                      old_idx_q, old_idx_d;
  logic [IDX_W-1:0]                      old_age_q, old_age_d;
  logic [NUM_VOICES-1:0]                 enable_q, enable_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]     notes_q, notes_d;
  logic [NUM_VOICES-1:0][IDX_W-1:0]      age_q, age_d;
  logic                                  done_q, done_d;
  logic [IDX_W-1:0]                      done_voice_q, done_voice_d;
  logic                                  done_stolen_q, done_stolen_d;
  logic                                  done_hit_q, done_hit_d;
  logic [IDX_W-1:0]                      target;

  assign req_ready    = (state_q == IDLE) && !reset;
  assign voice_enable = enable_q;
  assign voice_note   = notes_q;
  assign done         = done_q;
  assign done_voice   = done_voice_q;
  assign done_stolen  = done_stolen_q;
  assign done_hit     = done_hit_q;

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    on_d          = on_q;
    note_d        = note_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    enable_d      = enable_q;
    notes_d       = notes_q;
    age_d         = age_q;
    done_d        = 1'b0;
    done_voice_d  = done_voice_q;
    done_stolen_d = done_stolen_q;
    done_hit_d    = done_hit_q;
    target        = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          on_d          = req_on;
          note_d        = req_note;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          match_idx_d   = '0;
          free_idx_d    = '0;
          old_idx_d     = '0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        if (enable_q[scan_idx_q]) begin
          if (notes_q[scan_idx_q] == note_q) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx_q;
          end
          // Strict '>' keeps the lowest index among equally old voices.
          if (!old_found_q || (age_q[scan_idx_q] > old_age_q)) begin
            old_found_d = 1'b1;
            old_idx_d   = scan_idx_q;
            old_age_d   = age_q[scan_idx_q];
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (on_q) begin
          if (match_found_q)     target = match_idx_q;
          else if (free_found_q) target = free_idx_q;
          else                   target = old_idx_q;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == target) begin
              enable_d[i] = 1'b1;
              notes_d[i]  = note_q;
              age_d[i]    = '0;
            end else if (enable_q[i] && (age_q[i] != AGE_MAX)) begin
              age_d[i] = age_q[i] + IDX_W'(1);
            end
          end
          done_voice_d  = target;
          done_stolen_d = !match_found_q && !free_found_q;
          done_hit_d    = 1'b1;
        end else if (match_found_q) begin
          enable_d[match_idx_q] = 1'b0;
          age_d[match_idx_q]    = '0;
          done_voice_d          = match_idx_q;
          done_stolen_d         = 1'b0;
          done_hit_d            = 1'b1;
        end else begin
          done_voice_d  = '0;
          done_stolen_d = 1'b0;
          done_hit_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      on_q          <= 1'b0;
      note_q        <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      enable_q      <= '0;
      notes_q       <= '0;
      age_q         <= '0;
      done_q        <= 1'b0;
      done_voice_q  <= '0;
      done_stolen_q <= 1'b0;
      done_hit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      on_q          <= on_d;
      note_q        <= note_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      enable_q      <= enable_d;
      notes_q       <= notes_d;
      age_q         <= age_d;
      done_q        <= done_d;
      done_voice_q  <= done_voice_d;
      done_stolen_q <= done_stolen_d;
      done_hit_q    <= done_hit_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Directed self-checking bench for voice_allocator (4 voices).
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_on;
  logic [6:0]  req_note;
  logic [3:0]  voice_enable;
  logic [27:0] voice_note;
  logic        done;
  logic [1:0]  done_voice;
  logic        done_stolen;
  logic        done_hit;

  int errors = 0;
  int checks = 0;

  voice_allocator #(.NUM_VOICES(4), .NOTE_W(7)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_on       (req_on),
    .req_note     (req_note),
    .voice_enable (voice_enable),
    .voice_note   (voice_note),
    .done         (done),
    .done_voice   (done_voice),
    .done_stolen  (done_stolen),
    .done_hit     (done_hit)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns at the negedge following its done pulse.
  task automatic send(input int step, input logic on, input logic [6:0] note);
    int lat;
    int rdy_hi;
    int unstable;
    logic [3:0]  en0;
    logic [27:0] nt0;
    @(negedge sys_clk);
    chk($sformatf("s%0d_done_prev_low", step), done, 1'b0);
    req_valid = 1'b1;
    req_on    = on;
    req_note  = note;
    #1;
    chk($sformatf("s%0d_ready_idle", step), req_ready, 1'b1);
    en0 = voice_enable;
    nt0 = voice_note;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
    req_on    = ~on;
    req_note  = note ^ 7'h55;
    lat = 0; rdy_hi = 0; unstable = 0;
    while (lat < 10 && !done) begin
      if (req_ready) rdy_hi++;
      if (voice_enable !== en0 || voice_note !== nt0) unstable++;
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    chk($sformatf("s%0d_latency", step), lat, 5);
    chk($sformatf("s%0d_busy_ready_hi", step), rdy_hi, 0);
    chk($sformatf("s%0d_outputs_unstable", step), unstable, 0);
    chk($sformatf("s%0d_ready_in_done", step), req_ready, 1'b1);
  endtask

  task automatic result(input int step, input logic [1:0] v, input logic st, input logic hit,
                        input logic [3:0] en, input logic [27:0] notes);
    chk($sformatf("s%0d_done_voice", step), done_voice, v);
    chk($sformatf("s%0d_done_stolen", step), done_stolen, st);
    chk($sformatf("s%0d_done_hit", step), done_hit, hit);
    chk($sformatf("s%0d_enable", step), voice_enable, en);
    chk($sformatf("s%0d_notes", step), voice_note, notes);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int bad;
    reset = 1'b1; req_valid = 1'b0; req_on = 1'b0; req_note = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_enable", voice_enable, 4'b0000);
    chk("rst_notes", voice_note, 28'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {done_voice, done_stolen, done_hit}, 4'b0000);
    reset = 1'b0;
    #1 chk("rst_release_ready", req_ready, 1'b1);

    // Fill all voices, then steal the oldest.
    send(1, 1'b1, 7'd60);  result(1, 2'd0, 1'b0, 1'b1, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd60});
    send(2, 1'b1, 7'd62);  result(2, 2'd1, 1'b0, 1'b1, 4'b0011, {7'd0, 7'd0, 7'd62, 7'd60});
    send(3, 1'b1, 7'd64);  result(3, 2'd2, 1'b0, 1'b1, 4'b0111, {7'd0, 7'd64, 7'd62, 7'd60});
    send(4, 1'b1, 7'd67);  result(4, 2'd3, 1'b0, 1'b1, 4'b1111, {7'd67, 7'd64, 7'd62, 7'd60});
    send(5, 1'b1, 7'd69);  result(5, 2'd0, 1'b1, 1'b1, 4'b1111, {7'd67, 7'd64, 7'd62, 7'd69});
    send(6, 1'b1, 7'd71);  result(6, 2'd1, 1'b1, 1'b1, 4'b1111, {7'd67, 7'd64, 7'd71, 7'd69});
    // Note-off hit and miss.
    send(7, 1'b0, 7'd64);  result(7, 2'd2, 1'b0, 1'b1, 4'b1011, {7'd67, 7'd64, 7'd71, 7'd69});
    send(8, 1'b0, 7'd50);  result(8, 2'd0, 1'b0, 1'b0, 4'b1011, {7'd67, 7'd64, 7'd71, 7'd69});
    // Note 0 fills the freed slot, then retriggers.
    send(9, 1'b1, 7'd0);   result(9, 2'd2, 1'b0, 1'b1, 4'b1111, {7'd67, 7'd0, 7'd71, 7'd69});
    send(10, 1'b1, 7'd0);  result(10, 2'd2, 1'b0, 1'b1, 4'b1111, {7'd67, 7'd0, 7'd71, 7'd69});
    // Voices 0 and 3 are both saturated at age 3: lowest index is stolen.
    send(11, 1'b1, 7'd5);  result(11, 2'd0, 1'b1, 1'b1, 4'b1111, {7'd67, 7'd0, 7'd71, 7'd5});

    // Retrigger age behaviour.
    do_reset();
    send(12, 1'b1, 7'd60);
    send(13, 1'b1, 7'd62);
    send(14, 1'b1, 7'd64);
    send(15, 1'b0, 7'd64);
    send(16, 1'b1, 7'd60); result(16, 2'd0, 1'b0, 1'b1, 4'b0011, {7'd0, 7'd64, 7'd62, 7'd60});
    chk("s16_age_v0", 32'(dut.age_q[0]), 32'd0);
    chk("s16_age_v1", 32'(dut.age_q[1]), 32'd2);

    // Reset asserted at E2 of an in-flight note-on.
    @(negedge sys_clk);
    req_valid = 1'b1; req_on = 1'b1; req_note = 7'd70;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mrst_ready", req_ready, 1'b0);
    chk("mrst_enable", voice_enable, 4'b0000);
    chk("mrst_notes", voice_note, 28'd0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_flags", {done_voice, done_stolen, done_hit}, 4'b0000);
    reset = 1'b0;
    #1 chk("mrst_ready_after", req_ready, 1'b1);
    dn = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (done) dn++;
    end
    chk("mrst_no_done", dn, 0);

    // Back-to-back with req_valid held high.
    @(negedge sys_clk);
    req_valid = 1'b1; req_on = 1'b1; req_note = 7'd80;
    dn = 0; bad = 0;
    for (int c = 0; c < 18; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (done) begin
        dn++;
        if (c % 6 != 5) bad++;
      end
      if (req_ready && (c % 6 != 5)) bad++;
    end
    req_valid = 1'b0;
    chk("b2b_done_count", dn, 3);
    chk("b2b_timing_errors", bad, 0);
    chk("b2b_enable", voice_enable, 4'b0001);
    chk("b2b_voice", done_voice, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
